// File: rtl/mysystem_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system ID slave.
interface mysystem_sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata
  );
endinterface

// File: rtl/mysystem_sysid_checker.sv
// System ID checker: reads the sysid slave's ID word (address 0) and build
// timestamp (address 1), compares them against compile-time expectations and
// reports pass/fail/timeout flags to the boot and status logic.
//
// Optional build macro SYSID_CHECK_PERIODIC_EN: adds RECHECK_PERIOD, an idle
// counter that re-runs the check periodically, and the mismatch_sticky output.
//
// state  | meaning
// IDLE   | no check running; waits for start, auto-start or periodic recheck
// RD_ID  | launch then hold the read of word 0 until accepted or timed out
// RD_TS  | hold the read of word 1 until accepted or timed out
// FINISH | one cycle: evaluate the captured words, raise done
module mysystem_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h87654321,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h695153D4,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int unsigned RECHECK_PERIOD     = 1_000_000
`endif
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  mysystem_sysid_checker_if.master avm,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [31:0]             sys_id,
  output logic [31:0]             sys_timestamp
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  output logic                    mismatch_sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Abort happens on the stalled cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       auto_pending;
  logic       accept;
  logic       stall;
  logic       abort;
  logic       go;
  logic       recheck_fire;
  logic       id_match;
  logic       ts_match;

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam logic [31:0] RECHECK_LAST = 32'(RECHECK_PERIOD - 1);
  logic [31:0] idle_cnt;

  // Idle counter runs only while a finished result is being held.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (state == IDLE && done) begin
      idle_cnt <= recheck_fire ? '0 : idle_cnt + 32'd1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // Sticky record of any failed check since reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mismatch_sticky <= 1'b0;
    end else if (state == FINISH && (timeout || !id_match || !ts_match)) begin
      mismatch_sticky <= 1'b1;
    end
  end

  assign recheck_fire = (state == IDLE) && done && (idle_cnt == RECHECK_LAST);
`else
  assign recheck_fire = 1'b0;
`endif

  // Handshake decode and next-state selection.
  always_comb begin
    accept     = avm.read && !avm.waitrequest;
    stall      = avm.read && avm.waitrequest;
    abort      = stall && (wait_cnt == TIMEOUT_LAST);
    go         = start || auto_pending || recheck_fire;
    id_match   = (sys_id == EXPECTED_ID);
    ts_match   = (sys_timestamp == EXPECTED_TIMESTAMP);
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = RD_ID;
      RD_ID: begin
        if (abort)       state_next = FINISH;
        else if (accept) state_next = RD_TS;
      end
      RD_TS:   if (abort || accept) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Bus strobes, wait counter, captured words and result flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      avm.read      <= 1'b0;
      avm.address   <= 1'b0;
      wait_cnt      <= '0;
      auto_pending  <= AUTO_START;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      timeout       <= 1'b0;
      sys_id        <= '0;
      sys_timestamp <= '0;
    end else begin
      auto_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        RD_ID: begin
          // First cycle in RD_ID launches the read; later cycles track it.
          if (!avm.read) begin
            avm.read    <= 1'b1;
            avm.address <= 1'b0;
          end else if (abort) begin
            avm.read <= 1'b0;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else if (accept) begin
            sys_id      <= avm.readdata;
            avm.address <= 1'b1;
            wait_cnt    <= '0;
          end else if (stall) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_TS: begin
          if (abort) begin
            avm.read <= 1'b0;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else if (accept) begin
            sys_timestamp <= avm.readdata;
            avm.read      <= 1'b0;
            wait_cnt      <= '0;
          end else if (stall) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FINISH: begin
          // read is already low here, so address may return to 0 safely.
          avm.address <= 1'b0;
          id_ok       <= id_match && !timeout;
          ts_ok       <= ts_match && !timeout;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: begin
          avm.read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// Bench for mysystem_sysid_checker: behavioural sysid slave with
// programmable stall/stuck behaviour, plus a reference model of each check.
module tb_mysystem_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'h87654321;
  localparam logic [31:0] EXP_TS = 32'h695153D4;
  localparam int          TMO    = 4;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] sys_id, sys_timestamp;
`ifdef SYSID_CHECK_PERIODIC_EN
  logic        mismatch_sticky;
`endif

  int checks = 0;
  int fails  = 0;

  mysystem_sysid_checker_if bus();

  mysystem_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO),
    .AUTO_START         (1'b1)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .RECHECK_PERIOD     (16)
`endif
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .avm           (bus.master),
    .busy          (busy),
    .done          (done),
    .id_ok         (id_ok),
    .ts_ok         (ts_ok),
    .timeout       (timeout),
    .sys_id        (sys_id),
    .sys_timestamp (sys_timestamp)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .mismatch_sticky (mismatch_sticky)
`endif
  );

  always #5 clock = ~clock;

  // Slave model: two words, N stall cycles per read, optional stuck address.
  logic [31:0] mem [2];
  int stall_cycles = 0;
  int stuck_addr   = -1;
  int stall_cnt    = 0;

  assign bus.waitrequest = bus.read &&
                           ((stall_cnt < stall_cycles) || (stuck_addr == int'(bus.address)));
  assign bus.readdata    = bus.read ? mem[bus.address] : 32'h0;

  always @(posedge clock) begin
    if (!bus.read || !bus.waitrequest) stall_cnt <= 0;
    else                               stall_cnt <= stall_cnt + 1;
  end

  // Bus monitor: read-high cycles and address changes during a stall.
  int   read_cycles = 0;
  int   addr_viol   = 0;
  logic prev_stall  = 1'b0;
  logic prev_addr   = 1'b0;

  always @(posedge clock) begin
    if (bus.read) read_cycles <= read_cycles + 1;
    if (prev_stall && bus.read && (bus.address != prev_addr)) addr_viol <= addr_viol + 1;
    prev_stall <= bus.read && bus.waitrequest;
    prev_addr  <= bus.address;
  end

  // Reference model of the captured words and the expected outcome.
  logic [31:0] m_sys_id = 32'h0;
  logic [31:0] m_sys_ts = 32'h0;
  logic        e_id_ok, e_ts_ok, e_tmo;
  int          e_lat, e_reads;

  task automatic predict();
    bit tmo_id, tmo_ts;
    tmo_id  = (stuck_addr == 0) || (stall_cycles >= TMO);
    tmo_ts  = !tmo_id && ((stuck_addr == 1) || (stall_cycles >= TMO));
    e_tmo   = tmo_id || tmo_ts;
    if (!tmo_id) m_sys_id = mem[0];
    if (!e_tmo)  m_sys_ts = mem[1];
    e_id_ok = !e_tmo && (m_sys_id == EXP_ID);
    e_ts_ok = !e_tmo && (m_sys_ts == EXP_TS);
    e_lat   = e_tmo ? -1 : 4 + 2 * stall_cycles;
    if (tmo_id)      e_reads = TMO;
    else if (tmo_ts) e_reads = (stall_cycles + 1) + TMO;
    else             e_reads = 2 * (stall_cycles + 1);
  endtask

  // Starts a check (start pulse or reset release) and counts edges to done.
  task automatic launch(input bit use_start, output int cycles, output bit got);
    if (use_start) begin
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
    end else begin
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock);
    end
    cycles = 0;
    got    = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clock); #1;
      cycles++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, id_ok, ts_ok, timeout} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, id_ok, ts_ok, timeout});
    end
    checks++;
    if (bus.read !== 1'b0 || bus.address !== 1'b0) begin
      fails++; $display("FAIL reset_bus: read=%b address=%b expected 0 0", bus.read, bus.address);
    end
    checks++;
    if (sys_id !== 32'h0 || sys_timestamp !== 32'h0) begin
      fails++; $display("FAIL reset_words: got %h %h expected 0 0", sys_id, sys_timestamp);
    end
`ifdef SYSID_CHECK_PERIODIC_EN
    checks++;
    if (mismatch_sticky !== 1'b0) begin
      fails++; $display("FAIL reset_sticky: got %b expected 0", mismatch_sticky);
    end
`endif
  endtask

  task automatic test_auto_start();
    int cyc, r0; bit got;
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_cycles = 0; stuck_addr = -1;
    m_sys_id = 32'h0; m_sys_ts = 32'h0;
    predict();
    r0 = read_cycles;
    launch(1'b0, cyc, got);
    checks++;
    if (!got || cyc != e_lat) begin
      fails++; $display("FAIL auto_latency: got %0d (done=%b) expected %0d", cyc, got, e_lat);
    end
    checks++;
    if (read_cycles - r0 != e_reads) begin
      fails++; $display("FAIL auto_read_cycles: got %0d expected %0d", read_cycles - r0, e_reads);
    end
    checks++;
    if ({id_ok, ts_ok, timeout, busy} !== {e_id_ok, e_ts_ok, e_tmo, 1'b0}) begin
      fails++; $display("FAIL auto_flags: got %b expected %b", {id_ok, ts_ok, timeout, busy},
                        {e_id_ok, e_ts_ok, e_tmo, 1'b0});
    end
    checks++;
    if (sys_id !== m_sys_id || sys_timestamp !== m_sys_ts) begin
      fails++; $display("FAIL auto_words: got %h %h expected %h %h", sys_id, sys_timestamp, m_sys_id, m_sys_ts);
    end
  endtask

  task automatic test_id_mismatch();
    int cyc; bit got;
    mem[0] = 32'h87654320; mem[1] = EXP_TS; stall_cycles = 0; stuck_addr = -1;
    predict();
    launch(1'b1, cyc, got);
    checks++;
    if (!got || {id_ok, ts_ok, timeout} !== 3'b010) begin
      fails++; $display("FAIL mismatch_flags: got %b (done=%b) expected 010", {id_ok, ts_ok, timeout}, got);
    end
    checks++;
    if (sys_id !== 32'h87654320) begin
      fails++; $display("FAIL mismatch_sys_id: got %h expected 87654320", sys_id);
    end
  endtask

  task automatic test_stall();
    int cyc, v0; bit got;
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_cycles = 3; stuck_addr = -1;
    predict();
    v0 = addr_viol;
    launch(1'b1, cyc, got);
    checks++;
    if (!got || cyc != 10) begin
      fails++; $display("FAIL stall_latency: got %0d (done=%b) expected 10", cyc, got);
    end
    checks++;
    if (addr_viol != v0) begin
      fails++; $display("FAIL stall_addr_stable: got %0d changes expected 0", addr_viol - v0);
    end
    checks++;
    if ({id_ok, ts_ok, timeout} !== 3'b110 || sys_id !== EXP_ID || sys_timestamp !== EXP_TS) begin
      fails++; $display("FAIL stall_capture: got %b %h %h expected 110 %h %h",
                        {id_ok, ts_ok, timeout}, sys_id, sys_timestamp, EXP_ID, EXP_TS);
    end
  endtask

  task automatic test_timeout();
    int cyc, r0; bit got;
    mem[0] = EXP_ID; mem[1] = 32'h12345678; stall_cycles = 0; stuck_addr = 1;
    predict();
    r0 = read_cycles;
    launch(1'b1, cyc, got);
    checks++;
    if (!got || {id_ok, ts_ok, timeout} !== 3'b001) begin
      fails++; $display("FAIL timeout_flags: got %b (done=%b) expected 001", {id_ok, ts_ok, timeout}, got);
    end
    checks++;
    if (sys_timestamp !== EXP_TS || bus.read !== 1'b0) begin
      fails++; $display("FAIL timeout_ts_kept: got %h read=%b expected %h read=0", sys_timestamp, bus.read, EXP_TS);
    end
    checks++;
    if (read_cycles - r0 != e_reads) begin
      fails++; $display("FAIL timeout_read_cycles: got %0d expected %0d", read_cycles - r0, e_reads);
    end
    stuck_addr = -1;
  endtask

  task automatic test_random();
    int cyc, r0, v0; bit got;
    for (int it = 0; it < 24; it++) begin
      mem[0] = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom;
      mem[1] = ($urandom_range(0, 1) != 0) ? EXP_TS : EXP_TS ^ (32'h1 << $urandom_range(0, 31));
      stall_cycles = $urandom_range(0, 3);
      stuck_addr   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1;
      predict();
      r0 = read_cycles; v0 = addr_viol;
      launch(1'b1, cyc, got);
      checks++;
      if (!got) begin
        fails++; $display("FAIL rand_done[%0d]: got no done expected done", it);
        continue;
      end
      checks++;
      if ({id_ok, ts_ok, timeout} !== {e_id_ok, e_ts_ok, e_tmo}) begin
        fails++; $display("FAIL rand_flags[%0d]: got %b expected %b", it, {id_ok, ts_ok, timeout},
                          {e_id_ok, e_ts_ok, e_tmo});
      end
      checks++;
      if (sys_id !== m_sys_id || sys_timestamp !== m_sys_ts) begin
        fails++; $display("FAIL rand_words[%0d]: got %h %h expected %h %h", it, sys_id, sys_timestamp,
                          m_sys_id, m_sys_ts);
      end
      checks++;
      if (read_cycles - r0 != e_reads || addr_viol != v0) begin
        fails++; $display("FAIL rand_bus[%0d]: got reads %0d viol %0d expected %0d 0", it,
                          read_cycles - r0, addr_viol - v0, e_reads);
      end
      if (e_lat >= 0) begin
        checks++;
        if (cyc != e_lat) begin
          fails++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, cyc, e_lat);
        end
      end
    end
    stuck_addr = -1; stall_cycles = 0;
  endtask

  task automatic test_back_to_back();
    int cyc, r0; bit got;
    mem[0] = EXP_ID; mem[1] = EXP_TS; stall_cycles = 0; stuck_addr = -1;
    predict();
    r0 = read_cycles;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(posedge clock); @(posedge clock);
    // start held across RD_TS and the FINISH cycle: both samples ignored.
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    @(negedge clock); start = 1'b0;
    checks++;
    if (done !== 1'b1 || {id_ok, ts_ok} !== 2'b11) begin
      fails++; $display("FAIL b2b_done: got done=%b ok=%b expected 1 11", done, {id_ok, ts_ok});
    end
    repeat (6) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || read_cycles - r0 != 2) begin
      fails++; $display("FAIL b2b_ignored: got busy=%b reads=%0d expected 0 2", busy, read_cycles - r0);
    end
    // Second run stalled in RD_ID, then reset mid-read.
    stuck_addr = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.read !== 1'b1 || bus.address !== 1'b0) begin
      fails++; $display("FAIL b2b_in_rd_id: got read=%b address=%b expected 1 0", bus.read, bus.address);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.read !== 1'b0 || {busy, done, id_ok, ts_ok, timeout} !== 5'b0 ||
        sys_id !== 32'h0 || sys_timestamp !== 32'h0) begin
      fails++; $display("FAIL midread_reset: got read=%b flags=%b words=%h %h expected all 0", bus.read,
                        {busy, done, id_ok, ts_ok, timeout}, sys_id, sys_timestamp);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || bus.read !== 1'b0) begin
      fails++; $display("FAIL midread_no_done: got done=%b read=%b expected 0 0", done, bus.read);
    end
    stuck_addr = -1;
    m_sys_id = 32'h0; m_sys_ts = 32'h0;
    predict();
    launch(1'b0, cyc, got);
    checks++;
    if (!got || cyc != e_lat || {id_ok, ts_ok, timeout} !== 3'b110) begin
      fails++; $display("FAIL post_reset_auto: got cyc=%0d flags=%b expected %0d 110", cyc,
                        {id_ok, ts_ok, timeout}, e_lat);
    end
  endtask

`ifdef SYSID_CHECK_PERIODIC_EN
  task automatic test_periodic();
    int gap; bit seen;
    mem[0] = EXP_ID ^ 32'h1;
    // Result of the previous passing check is now held; count idle cycles to rerun.
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #1;
      gap++;
      if (busy) seen = 1'b1;
    end
    checks++;
    if (!seen || gap > 16) begin
      fails++; $display("FAIL periodic_rerun: got gap %0d (seen=%b) expected at most 16", gap, seen);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || id_ok !== 1'b0 || mismatch_sticky !== 1'b1) begin
      fails++; $display("FAIL periodic_result: got id_ok=%b sticky=%b expected 0 1", id_ok, mismatch_sticky);
    end
    mem[0] = EXP_ID;
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (mismatch_sticky !== 1'b1) begin
      fails++; $display("FAIL periodic_sticky_held: got %b expected 1", mismatch_sticky);
    end
  endtask
`endif

  initial begin
    mem[0] = EXP_ID;
    mem[1] = EXP_TS;
    test_reset();
    test_auto_start();
    test_id_mismatch();
    test_stall();
    test_timeout();
    test_random();
    test_back_to_back();
`ifdef SYSID_CHECK_PERIODIC_EN
    test_periodic();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mysystem_sysid_checker.md
Name: mysystem_sysid_checker

Overview:
Avalon-MM master that sits directly downstream of the system ID slave and consumes its readdata. After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp) and compares each against compile-time expected values. It then latches the words read and raises pass/fail flags for the boot/status logic and the CPU status PIO. A bounded waitrequest timeout keeps a hung slave from stalling boot.

Parameters:
EXPECTED_ID, 32'h87654321, expected word at address 0
EXPECTED_TIMESTAMP, 32'h695153D4, expected word at address 1
TIMEOUT_CYCLES, 255, max consecutive waitrequest cycles per read before abort; 8-bit counter, legal range 1..255
AUTO_START, 1, 1 = begin a check on the first cycle after reset release

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  single-cycle request to (re)run the check; ignored while busy
address  out  1  Avalon address to sysid slave (0 = ID, 1 = timestamp)
read  out  1  Avalon read strobe
waitrequest  in  1  slave stall; tie 0 for the zero-wait sysid slave
readdata  in  32  slave read data, valid in the cycle read=1 and waitrequest=0
busy  out  1  check in progress
done  out  1  check finished; held until next start
id_ok  out  1  word 0 matched EXPECTED_ID
ts_ok  out  1  word 1 matched EXPECTED_TIMESTAMP
timeout  out  1  a read exceeded TIMEOUT_CYCLES
sys_id  out  32  last captured word 0
sys_timestamp  out  32  last captured word 1

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0; state IDLE; wait counter 0. Reset mid-read drops read the next cycle, and no partial results survive.
- States: IDLE, RD_ID, RD_TS, FINISH.
- IDLE: read=0. Go to RD_ID when start=1, or on the first post-reset cycle if AUTO_START=1. On entry to RD_ID: busy=1; done, id_ok, ts_ok and timeout cleared; sys_id/sys_timestamp keep their old values until overwritten.
- RD_ID: address=0, read=1, both held stable while waitrequest=1.
  - On the cycle read&!waitrequest: capture readdata into sys_id, reset the wait counter, go to RD_TS.
- RD_TS: address=1, read=1.
  - On accept: capture readdata into sys_timestamp, go to FINISH.
- Wait counter: increments each cycle read=1&waitrequest=1. If it reaches TIMEOUT_CYCLES while waitrequest is still 1, set timeout=1, drop read, go to FINISH. The word not read keeps its old value and its ok flag stays 0.
- FINISH (one cycle): id_ok <= (sys_id==EXPECTED_ID); ts_ok <= (sys_timestamp==EXPECTED_TIMESTAMP). Both are forced 0 when timeout=1. busy=0, done=1, return to IDLE.
- Latency with waitrequest=0: start sampled at edge N. read asserted N+1 (ID) and N+2 (TS). done, id_ok and ts_ok visible after edge N+4.
- start while busy: ignored, not queued.
- start in the same cycle as done rising: ignored, because the block is still busy. start on any cycle after done=1 re-runs the check.
- read is never asserted outside RD_ID/RD_TS. address only changes when read=0 or on the accept cycle.

Optional Feature:
SYSID_CHECK_PERIODIC_EN
- Defined:
  - Adds parameter RECHECK_PERIOD (default 1_000_000) and a 32-bit idle counter.
  - In IDLE with done=1, the counter increments each cycle. On reaching RECHECK_PERIOD it clears and starts a new check, as if start=1.
  - Adds output mismatch_sticky (1 bit, reset 0). It is set whenever a completed check yields id_ok=0, ts_ok=0 or timeout=1, and is cleared only by reset.
- Not defined: no counter, no extra parameter, no mismatch_sticky port. The check runs only from AUTO_START or start.

Test Plan:
1. Reset release, AUTO_START=1, slave returns 0x87654321 at addr 0 and 0x695153D4 at addr 1, waitrequest=0 -> read high exactly 2 cycles (addr 0 then 1); done=1, id_ok=1, ts_ok=1, timeout=0 four cycles after reset release.
2. Slave returns 0x87654320 at addr 0 -> done=1, id_ok=0, ts_ok=1, sys_id=0x87654320.
3. waitrequest=1 for 3 cycles on each read -> address/read stable while stalled; correct capture; done 10 cycles after start.
4. TIMEOUT_CYCLES=4, waitrequest stuck 1 on addr 1 -> timeout=1, id_ok=0, ts_ok=0, read deasserted, sys_timestamp unchanged.
5. start pulsed during RD_TS, then reset_n=0 mid-RD_ID of a second run -> first pulse ignored; after reset all outputs 0 and read=0; no spurious done.
6. With SYSID_CHECK_PERIODIC_EN, RECHECK_PERIOD=16: first check passes; slave then changes the ID -> rerun starts 16 cycles after done, id_ok=0, mismatch_sticky=1 and held.
